// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if
//   Groups the two streams the boot loader sits between.
//   byte_valid/byte_in : byte stream from the UART receiver.
//   imem_we/imem_addr/imem_wdata : word write port into instruction memory.
//
// Handshake semantics: both streams are strobe-only, with no ready signal.
// A byte transfers on every clock edge where byte_valid=1. A word writes on
// every clock edge where imem_we=1. The consumer must accept every strobe.
// imem_addr and imem_wdata are meaningful only while imem_we=1.
//
// Modports:
//   master : the byte source and imem sink (the testbench or the SoC glue).
//   slave  : the boot loader.
interface uart_boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  byte_valid;
    logic [7:0]            byte_in;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output byte_valid,
        output byte_in,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_in,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Parses a framed program image arriving as UART byte strobes and writes it
//   into instruction memory. The CPU is held in reset until a frame completes
//   with a matching XOR checksum.
//   Frame layout: LEN_LO LEN_HI {4*N data bytes, little-endian words} CSUM.
//
// Ports:
//   clk, rst     : clock and asynchronous active-high reset.
//   bus (slave)  : byte stream in, imem word write port out.
//   cpu_reset    : 1 holds the CPU in reset.
//   load_busy    : 1 while a frame is being received (LEN_HI, DATA, CSUM).
//   load_done    : one-cycle pulse when a load succeeds.
//   load_error   : level; the last load failed (bad length, checksum or timeout).
//   dbg_state_o  : current FSM state encoding, for observation only.
module uart_boot_loader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int MAX_WORDS    = 1024,
    parameter int BASE_ADDR    = 0,
    parameter int TIMEOUT_CLKS = 10_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_boot_loader_if.slave    bus,
    output logic                 cpu_reset,
    output logic                 load_busy,
    output logic                 load_done,
    output logic                 load_error,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_RUN    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam int              TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [15:0]     MAX_N    = 16'(MAX_WORDS);

    state_t                  state_q;
    logic [15:0]             len_q;
    logic [7:0]              csum_q;
    logic [23:0]             word_q;       // lanes 0..2; lane 3 comes straight from byte_in
    logic [1:0]              byte_idx_q;
    logic [15:0]             word_idx_q;
    logic [TW-1:0]           tmo_q;
    logic                    imem_we_q;
    logic [ADDR_WIDTH-1:0]   imem_addr_q;
    logic [31:0]             imem_wdata_q;
    logic                    cpu_reset_q;
    logic                    load_busy_q;
    logic                    load_done_q;
    logic                    load_error_q;

    // Next values derived from the byte currently on the bus.
    logic [15:0]             len_d;
    logic [7:0]              csum_d;
    logic                    in_frame;
    logic                    timeout_hit;
    logic                    last_word;

    always_comb begin
        len_d       = {bus.byte_in, len_q[7:0]};
        csum_d      = csum_q ^ bus.byte_in;
        in_frame    = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CSUM);
        // A byte arriving in the final cycle beats the timeout.
        timeout_hit = in_frame && !bus.byte_valid && (tmo_q == TMO_LAST);
        last_word   = (word_idx_q == (len_q - 16'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            csum_q       <= '0;
            word_q       <= '0;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            tmo_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_busy_q  <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            imem_we_q   <= 1'b0;
            load_done_q <= 1'b0;

            // Inter-byte idle counter: runs only inside a frame, any byte clears it.
            if (!in_frame || bus.byte_valid || timeout_hit) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (timeout_hit) begin
                state_q      <= S_ERR;
                load_error_q <= 1'b1;
                cpu_reset_q  <= 1'b1;
                load_busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    // Any byte outside a frame starts a new load, even while
                    // the CPU is running; the CPU goes back into reset.
                    S_IDLE, S_RUN, S_ERR: begin
                        if (bus.byte_valid) begin
                            len_q        <= {8'h00, bus.byte_in};
                            csum_q       <= bus.byte_in;
                            cpu_reset_q  <= 1'b1;
                            load_error_q <= 1'b0;
                            load_busy_q  <= 1'b1;
                            state_q      <= S_LEN_HI;
                        end
                    end

                    S_LEN_HI: begin
                        if (bus.byte_valid) begin
                            len_q  <= len_d;
                            csum_q <= csum_d;
                            if ((len_d == 16'd0) || (len_d > MAX_N)) begin
                                state_q      <= S_ERR;
                                load_error_q <= 1'b1;
                                cpu_reset_q  <= 1'b1;
                                load_busy_q  <= 1'b0;
                            end else begin
                                word_idx_q <= '0;
                                byte_idx_q <= '0;
                                state_q    <= S_DATA;
                            end
                        end
                    end

                    S_DATA: begin
                        if (bus.byte_valid) begin
                            csum_q     <= csum_d;
                            byte_idx_q <= byte_idx_q + 2'd1;
                            unique case (byte_idx_q)
                                2'd0: word_q[7:0]   <= bus.byte_in;
                                2'd1: word_q[15:8]  <= bus.byte_in;
                                2'd2: word_q[23:16] <= bus.byte_in;
                                2'd3: begin
                                    imem_we_q    <= 1'b1;
                                    imem_addr_q  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx_q);
                                    imem_wdata_q <= {bus.byte_in, word_q};
                                    word_idx_q   <= word_idx_q + 16'd1;
                                    if (last_word) begin
                                        state_q <= S_CSUM;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end

                    S_CSUM: begin
                        if (bus.byte_valid) begin
                            load_busy_q <= 1'b0;
                            if (bus.byte_in == csum_q) begin
                                state_q     <= S_RUN;
                                load_done_q <= 1'b1;
                                cpu_reset_q <= 1'b0;
                            end else begin
                                state_q      <= S_ERR;
                                load_error_q <= 1'b1;
                                cpu_reset_q  <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q     <= S_IDLE;
                        load_busy_q <= 1'b0;
                        cpu_reset_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign load_busy      = load_busy_q;
    assign load_done      = load_done_q;
    assign load_error     = load_error_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader
//   Directed bench for uart_boot_loader with TIMEOUT_CLKS=50.
//   Frames are sent from frame_q. A negedge monitor logs byte strobes and
//   status edges. It also scoreboards every imem write against exp_q.
module tb_uart_boot_loader;

    localparam int AW  = 10;
    localparam int TMO = 50;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_reset;
    logic       load_busy;
    logic       load_done;
    logic       load_error;
    logic [2:0] dbg_state;

    uart_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    uart_boot_loader #(
        .ADDR_WIDTH  (AW),
        .MAX_WORDS   (1024),
        .BASE_ADDR   (0),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_error (load_error),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / monitor ----------------
    int              errors = 0;
    int              checks = 0;
    logic [AW+31:0]  exp_q[$];
    logic [7:0]      frame_q[$];
    int              strobe_q[$];
    logic            prev_strobe = 1'b0;
    logic            err_prev = 1'b0;
    logic            cpurst_prev = 1'b1;
    int              err_rise_cyc = -1;
    int              rst_rise_cyc = -1;
    int              done_cnt = 0;
    int              done_cyc = -1;
    logic            done_cpu_reset = 1'b1;

    always @(negedge clk) begin
        logic [AW+31:0] exp_w;
        if (bus.imem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0h data=%08h, required no write", bus.imem_addr, bus.imem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                // A write must land exactly one cycle after the byte that completed the word.
                if ({bus.imem_addr, bus.imem_wdata} !== exp_w || !prev_strobe) begin
                    errors++;
                    $display("FAIL imem_write: addr=%0h data=%08h strobe_prev=%0b, required addr=%0h data=%08h strobe_prev=1",
                             bus.imem_addr, bus.imem_wdata, prev_strobe, exp_w[AW+31:32], exp_w[31:0]);
                end
            end
        end
        if (load_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_cpu_reset = cpu_reset;
        end
        if (load_error === 1'b1 && !err_prev) err_rise_cyc = cyc;
        if (cpu_reset === 1'b1 && !cpurst_prev) rst_rise_cyc = cyc;
        err_prev    = load_error;
        cpurst_prev = cpu_reset;
        prev_strobe = bus.byte_valid;
        if (bus.byte_valid === 1'b1) strobe_q.push_back(cyc);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        strobe_q.delete();
        exp_q.delete();
        done_cnt     = 0;
        done_cyc     = -1;
        err_rise_cyc = -1;
        rst_rise_cyc = -1;
    endtask

    // gap = idle cycles between strobes; 0 gives strobes on consecutive cycles.
    task automatic send_frame(input int gap);
        foreach (frame_q[i]) begin
            @(posedge clk); #1;
            bus.byte_valid = 1'b1;
            bus.byte_in    = frame_q[i];
            if (gap > 0) begin
                @(posedge clk); #1;
                bus.byte_valid = 1'b0;
                repeat (gap - 1) @(posedge clk);
            end
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %0b, required 1", cpu_reset); end
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL rst_imem_we: got %0b, required 0", bus.imem_we); end
        checks++; if (bus.imem_addr !== '0) begin errors++; $display("FAIL rst_imem_addr: got %0h, required 0", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 32'h0) begin errors++; $display("FAIL rst_imem_wdata: got %08h, required 0", bus.imem_wdata); end
        checks++; if ({load_busy, load_done, load_error} !== 3'b000) begin errors++; $display("FAIL rst_status: busy/done/err=%03b, required 000", {load_busy, load_done, load_error}); end
        rst = 1'b0;
        idle(4);
        @(negedge clk);
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d, required %0d", dbg_state, ST_IDLE); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset_idle: got %0b, required 1", cpu_reset); end
    endtask

    task automatic test_two_word_load();
        clear_logs();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
        exp_q.push_back({10'd0, 32'h0000_0013});
        exp_q.push_back({10'd1, 32'h0000_006F});
        send_frame(2);
        idle(4);
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL two_word_writes: %0d writes missing, required 0", exp_q.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL two_word_done_cnt: got %0d, required 1", done_cnt); end
        checks++; if (done_cyc != strobe_q[10] + 1) begin errors++; $display("FAIL two_word_done_cyc: got %0d, required %0d", done_cyc, strobe_q[10] + 1); end
        checks++; if (done_cpu_reset !== 1'b0) begin errors++; $display("FAIL two_word_release_with_done: got %0b, required 0", done_cpu_reset); end
        checks++; if ({cpu_reset, load_error, load_busy} !== 3'b000) begin errors++; $display("FAIL two_word_status: rst/err/busy=%03b, required 000", {cpu_reset, load_error, load_busy}); end
        checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL two_word_state: got %0d, required %0d", dbg_state, ST_RUN); end
    endtask

    task automatic test_bad_checksum();
        clear_logs();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7F};
        exp_q.push_back({10'd0, 32'h0000_0013});
        exp_q.push_back({10'd1, 32'h0000_006F});
        send_frame(1);
        idle(4);
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL badcs_writes: %0d writes missing, required 0", exp_q.size()); end
        checks++; if (rst_rise_cyc != strobe_q[0] + 1) begin errors++; $display("FAIL badcs_cpu_reset_rise: got %0d, required %0d", rst_rise_cyc, strobe_q[0] + 1); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL badcs_done: got %0d pulses, required 0", done_cnt); end
        checks++; if ({load_error, cpu_reset} !== 2'b11) begin errors++; $display("FAIL badcs_status: err/rst=%02b, required 11", {load_error, cpu_reset}); end
        checks++; if (err_rise_cyc != strobe_q[10] + 1) begin errors++; $display("FAIL badcs_err_cyc: got %0d, required %0d", err_rise_cyc, strobe_q[10] + 1); end
    endtask

    task automatic test_illegal_length();
        clear_logs();
        frame_q = '{8'h00, 8'h00};
        send_frame(1);
        idle(3);
        @(negedge clk);
        checks++; if (err_rise_cyc != strobe_q[1] + 1) begin errors++; $display("FAIL len0_err_cyc: got %0d, required %0d", err_rise_cyc, strobe_q[1] + 1); end
        checks++; if (dbg_state !== ST_ERR) begin errors++; $display("FAIL len0_state: got %0d, required %0d", dbg_state, ST_ERR); end
        clear_logs();
        frame_q = '{8'h01, 8'h04};
        send_frame(1);
        idle(3);
        @(negedge clk);
        checks++; if (err_rise_cyc != strobe_q[1] + 1) begin errors++; $display("FAIL len1025_err_cyc: got %0d, required %0d", err_rise_cyc, strobe_q[1] + 1); end
        checks++; if ({load_error, load_busy, cpu_reset} !== 3'b101) begin errors++; $display("FAIL len1025_status: err/busy/rst=%03b, required 101", {load_error, load_busy, cpu_reset}); end
    endtask

    task automatic test_timeout();
        clear_logs();
        frame_q = '{8'h02, 8'h00, 8'h13};
        send_frame(2);
        idle(60);
        @(negedge clk);
        checks++; if (err_rise_cyc != strobe_q[2] + TMO + 1) begin errors++; $display("FAIL timeout_cyc: got %0d, required %0d", err_rise_cyc, strobe_q[2] + TMO + 1); end
        checks++; if ({load_error, load_busy, cpu_reset} !== 3'b101) begin errors++; $display("FAIL timeout_status: err/busy/rst=%03b, required 101", {load_error, load_busy, cpu_reset}); end
        checks++; if (dbg_state !== ST_ERR) begin errors++; $display("FAIL timeout_state: got %0d, required %0d", dbg_state, ST_ERR); end
        clear_logs();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
        exp_q.push_back({10'd0, 32'h0000_0013});
        exp_q.push_back({10'd1, 32'h0000_006F});
        send_frame(3);
        idle(4);
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_recover_writes: %0d missing, required 0", exp_q.size()); end
        checks++; if ({done_cnt, load_error, cpu_reset} !== {32'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL timeout_recover: done=%0d err=%0b rst=%0b, required done=1 err=0 rst=0", done_cnt, load_error, cpu_reset); end
    endtask

    task automatic test_reset_mid_load();
        clear_logs();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        send_frame(1);
        @(negedge clk);
        checks++; if ({load_busy, dbg_state} !== {1'b1, ST_DATA}) begin errors++; $display("FAIL midrst_pre: busy=%0b state=%0d, required busy=1 state=%0d", load_busy, dbg_state, ST_DATA); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL midrst_cpu_reset: got %0b, required 1", cpu_reset); end
        checks++; if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin errors++; $display("FAIL midrst_imem: we=%0b addr=%0h data=%08h, required all 0", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
        checks++; if ({load_busy, load_done, load_error, dbg_state} !== {3'b000, ST_IDLE}) begin errors++; $display("FAIL midrst_status: busy/done/err=%03b state=%0d, required 000 state=0", {load_busy, load_done, load_error}, dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        @(negedge clk);
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_idle: state=%0d, required %0d", dbg_state, ST_IDLE); end
        clear_logs();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
        exp_q.push_back({10'd0, 32'h0000_0013});
        exp_q.push_back({10'd1, 32'h0000_006F});
        send_frame(1);
        idle(4);
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_reload_writes: %0d missing, required 0", exp_q.size()); end
        checks++; if ({done_cnt, cpu_reset, dbg_state} !== {32'd1, 1'b0, ST_RUN}) begin errors++; $display("FAIL midrst_reload: done=%0d rst=%0b state=%0d, required 1 0 %0d", done_cnt, cpu_reset, dbg_state, ST_RUN); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        // Checksum 0x28: XOR of all 14 preceding bytes.
        frame_q = '{8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'h01, 8'h00, 8'h00, 8'h00, 8'h28};
        exp_q.push_back({10'd0, 32'hDEAD_BEEF});
        exp_q.push_back({10'd1, 32'h1234_5678});
        exp_q.push_back({10'd2, 32'h0000_0001});
        send_frame(0);
        idle(4);
        @(negedge clk);
        checks++; if (rst_rise_cyc != strobe_q[0] + 1) begin errors++; $display("FAIL b2b_cpu_reset_rise: got %0d, required %0d", rst_rise_cyc, strobe_q[0] + 1); end
        checks++; if (strobe_q.size() != 15 || strobe_q[14] != strobe_q[0] + 14) begin errors++; $display("FAIL b2b_stimulus: %0d strobes, required 15 consecutive", strobe_q.size()); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_writes: %0d missing, required 0", exp_q.size()); end
        checks++; if (done_cnt != 1 || done_cyc != strobe_q[14] + 1) begin errors++; $display("FAIL b2b_done: cnt=%0d cyc=%0d, required cnt=1 cyc=%0d", done_cnt, done_cyc, strobe_q[14] + 1); end
        checks++; if ({cpu_reset, load_error, dbg_state} !== {2'b00, ST_RUN}) begin errors++; $display("FAIL b2b_status: rst=%0b err=%0b state=%0d, required 0 0 %0d", cpu_reset, load_error, dbg_state, ST_RUN); end
    endtask

    initial begin
        test_reset();
        test_two_word_load();
        test_bad_checksum();
        test_illegal_length();
        test_timeout();
        test_reset_mid_load();
        test_back_to_back();
        idle(5);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_scoreboard: %0d writes outstanding, required 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sequences the UART byte receiver to load a program image into instruction memory.
- Consumes one-cycle byte strobes and parses a framed image: length, little-endian 32-bit words, XOR checksum.
- Issues word writes to the imem write port.
- Holds the CPU in reset until a load completes with a matching checksum; releases it only then.

Parameters:
- ADDR_WIDTH, 10, imem word-address width.
- MAX_WORDS, 1024, largest legal word count; must be <= 2**ADDR_WIDTH and <= 65535.
- BASE_ADDR, 0, word address of the first written word.
- TIMEOUT_CLKS, 10_000_000, maximum idle clocks allowed between bytes inside a frame (100 ms at 100 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- byte_valid  input  1  one-cycle strobe from the UART receiver (its byte_received).
- byte_in  input  8  received byte; valid when byte_valid=1.
- imem_we  output  1  one-cycle imem word write enable.
- imem_addr  output  ADDR_WIDTH  imem word address.
- imem_wdata  output  32  imem write data.
- cpu_reset  output  1  holds the CPU in reset while 1.
- load_busy  output  1  a frame is in progress.
- load_done  output  1  one-cycle pulse on successful load.
- load_error  output  1  level; last load failed.

Behaviour:
- Frame format, in byte order:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4*N data bytes; each word is little-endian, so byte k of a word goes to bits [8k+7:8k].
  - CSUM: XOR of every preceding byte in the frame, including both length bytes.
- Reset (async, immediate): state=IDLE.
  - cpu_reset=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - load_busy=0, load_done=0, load_error=0.
  - All counters, the length register, the checksum accumulator and the word assembly register are 0.
- States and transitions:
  - IDLE / RUN / ERR: on byte_valid, latch LEN_LO; csum=byte; cpu_reset<=1; load_error<=0; go to LEN_HI. Any stray byte in RUN therefore restarts a load and re-resets the CPU.
  - LEN_HI: on byte_valid, form N and fold the byte into csum.
    - If N==0 or N>MAX_WORDS, go to ERR.
    - Otherwise clear word_idx and byte_idx and go to DATA.
  - DATA: on each byte_valid, insert the byte at lane byte_idx, fold it into csum, increment byte_idx (2-bit counter, wraps).
    - On lane 3: imem_we=1 in the following cycle, with imem_addr=BASE_ADDR+word_idx (truncated to ADDR_WIDTH) and imem_wdata=the assembled word. Then word_idx increments.
    - After word N-1 is written, go to CSUM.
  - CSUM: on byte_valid, compare the byte with csum.
    - Equal: go to RUN; load_done=1 for one cycle and cpu_reset=0 in that same cycle.
    - Not equal: go to ERR.
  - ERR: load_error=1 (level), cpu_reset=1.
- load_busy=1 exactly in LEN_HI, DATA and CSUM.
- imem_we is registered and at most one cycle wide. imem_addr and imem_wdata hold their last values when imem_we=0.
- Words already written before a checksum failure or timeout stay in imem; the CPU remains held in reset.
- Inter-byte timeout:
  - Counter is active in LEN_HI, DATA and CSUM, cleared on every byte_valid.
  - When the counter reaches TIMEOUT_CLKS-1 with no byte, go to ERR.
  - A byte arriving in that same cycle wins; no timeout.
- byte_valid on consecutive cycles must each be accepted; there is no backpressure.
- A byte arriving in the same cycle as a pending imem_we is processed normally.
- Reset mid-frame aborts the load and returns to the reset state. The CPU remains in reset until the next successful load.

Test Plan:
- Two-word load: send 02 00 13 00 00 00 6F 00 00 00 7E.
  - Expect imem writes 0->0x00000013 and 1->0x0000006F, each one cycle after the last byte of its word.
  - Expect a load_done pulse, cpu_reset falling on the same cycle, and load_error=0.
- Bad checksum: same frame with last byte 7F.
  - Expect both writes to occur, load_error=1, cpu_reset held 1, no load_done.
- Illegal length: frame 00 00 -> ERR right after the 2nd byte with no writes. Frame 01 04 (N=1025 > 1024) -> ERR.
- Timeout with TIMEOUT_CLKS=50: send 02 00 13, then go silent.
  - Expect ERR exactly 50 clocks after the last strobe.
  - Then a full valid frame loads correctly and clears load_error.
- Reset mid-load: assert rst after 3 data bytes.
  - Expect outputs at reset values asynchronously and no further writes.
  - A subsequent valid frame succeeds.
- Reload and stress: after RUN, send a new frame with byte_valid on consecutive cycles.
  - Expect cpu_reset to rise on the first byte, every byte to be captured, correct writes, and load_done.
